// File: rtl/sound_player.sv
// Plays back recorder memory one sample per interval and renders the current
// sample as a free-running PWM stream for an RC-filtered speaker.
module sound_player #(
    parameter int SAMPLE_INTERVAL_CLK = 3000,
    parameter int PWM_BITS            = 10,
    parameter int ADDR_WIDTH          = 19,
    parameter bit SIGNED_INPUT        = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_clk,
    input  logic                  play_n,
    input  logic [ADDR_WIDTH-1:0] write_pointer,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    input  logic [PWM_BITS-1:0]   read_data,
    output logic [PWM_BITS-1:0]   sample,
    output logic                  playing,
    output logic                  done,
    output logic                  pwm_out
);
    localparam int CNT_W = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_INTERVAL_CLK - 1);

    typedef enum logic [1:0] {IDLE, PLAY, LAST} state_t;

    state_t                state;
    logic [CNT_W-1:0]      interval_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [ADDR_WIDTH:0]   next_addr;
    logic                  interval_end;

    // Two's complement to offset-binary is just an MSB flip.
    function automatic logic [PWM_BITS-1:0] conv(input logic [PWM_BITS-1:0] d);
        return d ^ {SIGNED_INPUT, {(PWM_BITS-1){1'b0}}};
    endfunction

    // One extra bit so the end-of-data compare cannot wrap at the top of memory.
    assign next_addr    = {1'b0, read_pointer} + (ADDR_WIDTH+1)'(1);
    assign interval_end = (interval_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state        <= IDLE;
            read_pointer <= '0;
            interval_cnt <= '0;
            sample       <= '0;
            playing      <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    read_pointer <= '0;
                    sample       <= '0;
                    interval_cnt <= '0;
                    if (!play_n && (write_pointer != '0)) begin
                        state   <= PLAY;
                        playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (play_n) begin
                        state        <= IDLE;
                        playing      <= 1'b0;
                        sample       <= '0;
                        read_pointer <= '0;
                        interval_cnt <= '0;
                    end else if (interval_end) begin
                        interval_cnt <= '0;
                        sample       <= conv(read_data);
                        read_pointer <= next_addr[ADDR_WIDTH-1:0];
                        if (next_addr >= {1'b0, write_pointer})
                            state <= LAST;
                    end else begin
                        interval_cnt <= interval_cnt + CNT_W'(1);
                    end
                end
                LAST: begin
                    if (play_n) begin
                        state        <= IDLE;
                        playing      <= 1'b0;
                        sample       <= '0;
                        read_pointer <= '0;
                        interval_cnt <= '0;
                    end else if (interval_end) begin
                        state        <= IDLE;
                        playing      <= 1'b0;
                        done         <= 1'b1;
                        sample       <= '0;
                        read_pointer <= '0;
                        interval_cnt <= '0;
                    end else begin
                        interval_cnt <= interval_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

    // PWM period is fixed by the counter width, independent of sample timing.
    always_ff @(posedge clk) begin
        if (reset_clk) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            pwm_out <= (pwm_cnt < sample);
        end
    end

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: short interval, address*3 memory model, plus a
// signed-input instance fed a constant mid-scale word.
module tb_sound_player;
    localparam int N  = 8;
    localparam int PB = 10;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset_clk = 1'b1;
    logic          play_n = 1'b1;
    logic          mem_const = 1'b0;
    logic [AW-1:0] write_pointer = '0;
    logic [AW-1:0] read_pointer;
    logic [PB-1:0] read_data;
    logic [PB-1:0] sample;
    logic          playing, done, pwm_out;

    logic [AW-1:0] s_write_pointer = AW'(200);
    logic [AW-1:0] s_read_pointer;
    logic [PB-1:0] s_read_data = 10'h200;
    logic [PB-1:0] s_sample;
    logic          s_playing, s_done, s_pwm_out;

    always #5 clk = ~clk;

    always_comb begin
        read_data = '0;
        if (mem_const)
            read_data = PB'(256);
        else if (read_pointer < write_pointer)
            read_data = PB'(32'(read_pointer) * 3);
    end

    sound_player #(.SAMPLE_INTERVAL_CLK(N), .PWM_BITS(PB), .ADDR_WIDTH(AW), .SIGNED_INPUT(1'b0)) dut (
        .clk(clk), .reset_clk(reset_clk), .play_n(play_n),
        .write_pointer(write_pointer), .read_pointer(read_pointer), .read_data(read_data),
        .sample(sample), .playing(playing), .done(done), .pwm_out(pwm_out));

    sound_player #(.SAMPLE_INTERVAL_CLK(N), .PWM_BITS(PB), .ADDR_WIDTH(AW), .SIGNED_INPUT(1'b1)) dut_s (
        .clk(clk), .reset_clk(reset_clk), .play_n(play_n),
        .write_pointer(s_write_pointer), .read_pointer(s_read_pointer), .read_data(s_read_data),
        .sample(s_sample), .playing(s_playing), .done(s_done), .pwm_out(s_pwm_out));

    typedef struct {
        logic [PB-1:0] smp;
        logic [AW-1:0] rp;
    } exp_t;

    typedef struct {
        int wp0;
        int grow_at;
        int wp1;
        int stop_after;
        int nsamp;
        int exp_done;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vecs[5];
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    int            nseen = 0;
    int            pwm_hi = 0;
    int            s_pwm_hi = 0;
    bit            sb_en = 1'b0;
    bit            pwm_en = 1'b0;
    logic [AW-1:0] prev_rp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (pwm_en) begin
                pwm_hi   += int'(pwm_out);
                s_pwm_hi += int'(s_pwm_out);
            end
            if (sb_en && (read_pointer == prev_rp + AW'(1))) begin
                nseen++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_sample", 32'(sample), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sample", 32'(sample), 32'(e.smp));
                    check("sb_read_pointer", 32'(read_pointer), 32'(e.rp));
                end
            end
            prev_rp = read_pointer;
        end
    endtask

    task automatic do_reset();
        reset_clk = 1'b1;
        play_n    = 1'b1;
        mem_const = 1'b0;
        sb_en     = 1'b0;
        tick(2);
        reset_clk = 1'b0;
        exp_q.delete();
        done_cnt = 0;
        nseen    = 0;
    endtask

    initial begin
        bit any_play;
        bit finished;
        bit hit;
        exp_t e;

        vecs[0] = '{wp0: 4, grow_at: -1, wp1: 0, stop_after: -1, nsamp: 4, exp_done: 1};
        vecs[1] = '{wp0: 1, grow_at: -1, wp1: 0, stop_after: -1, nsamp: 1, exp_done: 1};
        vecs[2] = '{wp0: 2, grow_at: 1,  wp1: 5, stop_after: -1, nsamp: 5, exp_done: 1};
        vecs[3] = '{wp0: 6, grow_at: -1, wp1: 0, stop_after: 2,  nsamp: 2, exp_done: 0};
        vecs[4] = '{wp0: 3, grow_at: -1, wp1: 0, stop_after: -1, nsamp: 3, exp_done: 1};

        // Reset held with a play request pending.
        reset_clk     = 1'b1;
        play_n        = 1'b0;
        write_pointer = AW'(4);
        for (int c = 0; c < 2; c++) begin
            tick(1);
            check("rst_playing", 32'(playing), 32'd0);
            check("rst_read_pointer", 32'(read_pointer), 32'd0);
            check("rst_sample", 32'(sample), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_pwm_out", 32'(pwm_out), 32'd0);
        end

        // Exact first-sample latency.
        reset_clk = 1'b0;
        tick(1);
        check("lat_enter_play", 32'(playing), 32'd1);
        tick(7);
        check("lat_rp_before", 32'(read_pointer), 32'd0);
        tick(1);
        check("lat_rp_first", 32'(read_pointer), 32'd1);
        check("lat_sample_first", 32'(sample), 32'd0);
        tick(7);
        check("lat_rp_hold", 32'(read_pointer), 32'd1);
        tick(1);
        check("lat_rp_second", 32'(read_pointer), 32'd2);
        check("lat_sample_second", 32'(sample), 32'd3);
        play_n = 1'b1;
        tick(1);
        check("lat_stop_playing", 32'(playing), 32'd0);

        // Table of playback scenarios checked through the scoreboard.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            write_pointer = AW'(vecs[v].wp0);
            for (int i = 0; i < vecs[v].nsamp; i++) begin
                e.smp = PB'(i * 3);
                e.rp  = AW'(i + 1);
                exp_q.push_back(e);
            end
            prev_rp  = read_pointer;
            sb_en    = 1'b1;
            play_n   = 1'b0;
            finished = 1'b0;
            for (int c = 0; c < 400 && !finished; c++) begin
                tick(1);
                if (vecs[v].grow_at >= 0 && nseen == vecs[v].grow_at)
                    write_pointer = AW'(vecs[v].wp1);
                if (done) begin
                    play_n = 1'b1;
                    check($sformatf("v%0d_done_sample", v), 32'(sample), 32'd0);
                    check($sformatf("v%0d_done_rp", v), 32'(read_pointer), 32'd0);
                    check($sformatf("v%0d_done_playing", v), 32'(playing), 32'd0);
                    finished = 1'b1;
                end else if (vecs[v].stop_after >= 0 && nseen == vecs[v].stop_after) begin
                    tick(3);
                    play_n = 1'b1;
                    tick(1);
                    check($sformatf("v%0d_stop_playing", v), 32'(playing), 32'd0);
                    check($sformatf("v%0d_stop_sample", v), 32'(sample), 32'd0);
                    check($sformatf("v%0d_stop_rp", v), 32'(read_pointer), 32'd0);
                    tick(20);
                    finished = 1'b1;
                end
            end
            check($sformatf("v%0d_finished", v), 32'(finished), 32'd1);
            check($sformatf("v%0d_done_count", v), 32'(done_cnt), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_samples_seen", v), 32'(nseen), 32'(vecs[v].nsamp));
            check($sformatf("v%0d_queue_left", v), 32'(exp_q.size()), 32'd0);
        end

        // Empty memory: a play request must not start anything.
        do_reset();
        write_pointer = '0;
        play_n   = 1'b0;
        any_play = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            any_play |= playing;
        end
        check("empty_playing", 32'(any_play), 32'd0);
        check("empty_rp", 32'(read_pointer), 32'd0);
        check("empty_done", 32'(done_cnt), 32'd0);
        play_n = 1'b1;

        // PWM duty at sample 256, and the signed instance fed 10'h200.
        do_reset();
        mem_const     = 1'b1;
        write_pointer = AW'(200);
        play_n        = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            tick(1);
            if (read_pointer != '0) hit = 1'b1;
        end
        check("pwm_first_sample", 32'(hit), 32'd1);
        tick(2);
        pwm_hi   = 0;
        s_pwm_hi = 0;
        pwm_en   = 1'b1;
        tick(1024);
        pwm_en   = 1'b0;
        check("pwm_sample", 32'(sample), 32'd256);
        check("pwm_high_count", 32'(pwm_hi), 32'd256);
        check("signed_playing", 32'(s_playing), 32'd1);
        check("signed_sample", 32'(s_sample), 32'd0);
        check("signed_pwm_high_count", 32'(s_pwm_hi), 32'd0);
        play_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
